// File: rtl/rr_mux_4_1_arbiter_pkg.sv
// rr_mux_pkg: shared widths, FSM state type and grant decode for the round-robin mux arbiter
package rr_mux_pkg;
    localparam int N_REQ  = 4;
    localparam int SEL_W  = 2;
    localparam int DATA_W = 4;

    typedef enum logic {IDLE, HOLD} rr_state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction
endpackage

// File: rtl/rr_mux_4_1_arbiter_if.sv
// rr_mux_4_1_arbiter_if: four valid/ready requesters in, one registered valid/ready channel out
interface rr_mux_4_1_arbiter_if;
    import rr_mux_pkg::*;
    logic [N_REQ-1:0]  req_valid;
    logic [DATA_W-1:0] req_data0;
    logic [DATA_W-1:0] req_data1;
    logic [DATA_W-1:0] req_data2;
    logic [DATA_W-1:0] req_data3;
    logic [N_REQ-1:0]  req_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [SEL_W-1:0]  out_sel;
    logic              out_ready;

    modport slave (
        input  req_valid, req_data0, req_data1, req_data2, req_data3, out_ready,
        output req_ready, out_valid, out_data, out_sel
    );

    modport master (
        output req_valid, req_data0, req_data1, req_data2, req_data3, out_ready,
        input  req_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/mux_4_1.sv
// mux_4_1: 4:1 multiplexer for 4-bit data
module mux_4_1 (
    input  logic [3:0] d0_i,
    input  logic [3:0] d1_i,
    input  logic [3:0] d2_i,
    input  logic [3:0] d3_i,
    input  logic [1:0] sel_i,
    output logic [3:0] y_o
);
    always_comb y_o = sel_i[1] ? (sel_i[0] ? d3_i : d2_i) : (sel_i[0] ? d1_i : d0_i);
endmodule

// File: rtl/rr_mux_4_1_arbiter_pick4.sv
// rr_pick4: first valid requester found scanning upward from ptr, modulo 4
module rr_pick4
    import rr_mux_pkg::*;
(
    input  logic [N_REQ-1:0] req_valid_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic [SEL_W-1:0] gnt_o,
    output logic             any_o
);
    always_comb begin
        gnt_o = ptr_i;
        any_o = |req_valid_i;
        // scan farthest-first so the closest valid index to ptr wins
        for (int k = N_REQ - 1; k >= 0; k--)
            if (req_valid_i[ptr_i + SEL_W'(k)]) gnt_o = ptr_i + SEL_W'(k);
    end
endmodule

// File: rtl/rr_mux_4_1_arbiter.sv
// rr_mux_4_1_arbiter: round-robin arbiter sharing one registered 4-bit output among four requesters
module rr_mux_4_1_arbiter
    import rr_mux_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    rr_mux_4_1_arbiter_if.slave   bus
);
    rr_state_t         state_q, state_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d, out_sel_q, out_sel_d, gnt;
    logic [DATA_W-1:0] out_data_q, out_data_d, mux_y;
    logic              out_valid_q, out_valid_d, any, capture_en, cap;

    rr_pick4 u_pick (
        .req_valid_i(bus.req_valid),
        .ptr_i      (ptr_q),
        .gnt_o      (gnt),
        .any_o      (any)
    );

    mux_4_1 u_mux (
        .d0_i (bus.req_data0),
        .d1_i (bus.req_data1),
        .d2_i (bus.req_data2),
        .d3_i (bus.req_data3),
        .sel_i(gnt),
        .y_o  (mux_y)
    );

    assign capture_en = (state_q == IDLE) || bus.out_ready;
    // no handshake is offered while reset is held
    assign cap           = rst && capture_en && any;
    assign bus.req_ready = cap ? onehot(gnt) : '0;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (cap) begin
            state_d     = HOLD;
            ptr_d       = gnt + SEL_W'(1);
            out_valid_d = 1'b1;
            out_data_d  = mux_y;
            out_sel_d   = gnt;
        end else if (state_q == HOLD && bus.out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end
endmodule

// File: tb/tb_rr_mux_4_1_arbiter.sv
// tb_rr_mux_4_1_arbiter: directed vectors with hand-computed grants, data and handshakes
module tb_rr_mux_4_1_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    rr_mux_4_1_arbiter_if bus ();

    rr_mux_4_1_arbiter dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // drive inputs, check req_ready combinationally, then check registers after the edge
    task automatic step(input string tag, input logic r, input logic [3:0] v, input logic o,
                        input logic [3:0] e_rdy, input logic e_ov, input logic [3:0] e_d,
                        input logic [1:0] e_s);
        rst           = r;
        bus.req_valid = v;
        bus.out_ready = o;
        #1;
        chk({tag, ".req_ready"}, bus.req_ready, e_rdy);
        @(posedge clk);
        #1;
        chk({tag, ".out_valid"}, {3'b0, bus.out_valid}, {3'b0, e_ov});
        chk({tag, ".out_data"}, bus.out_data, e_d);
        chk({tag, ".out_sel"}, {2'b0, bus.out_sel}, {2'b0, e_s});
    endtask

    initial begin
        bus.req_data0 = 4'h5;
        bus.req_data1 = 4'h6;
        bus.req_data2 = 4'h7;
        bus.req_data3 = 4'h8;
        // reset held two cycles with everyone requesting
        step("rst0", 1'b0, 4'hF, 1'b0, 4'b0000, 1'b0, 4'h0, 2'd0);
        step("rst1", 1'b0, 4'hF, 1'b1, 4'b0000, 1'b0, 4'h0, 2'd0);
        // rotation 0,1,2,3,0,1,2,3 with no bubbles
        step("rot0", 1'b1, 4'hF, 1'b1, 4'b0001, 1'b1, 4'h5, 2'd0);
        step("rot1", 1'b1, 4'hF, 1'b1, 4'b0010, 1'b1, 4'h6, 2'd1);
        step("rot2", 1'b1, 4'hF, 1'b1, 4'b0100, 1'b1, 4'h7, 2'd2);
        step("rot3", 1'b1, 4'hF, 1'b1, 4'b1000, 1'b1, 4'h8, 2'd3);
        step("rot4", 1'b1, 4'hF, 1'b1, 4'b0001, 1'b1, 4'h5, 2'd0);
        step("rot5", 1'b1, 4'hF, 1'b1, 4'b0010, 1'b1, 4'h6, 2'd1);
        step("rot6", 1'b1, 4'hF, 1'b1, 4'b0100, 1'b1, 4'h7, 2'd2);
        step("rot7", 1'b1, 4'hF, 1'b1, 4'b1000, 1'b1, 4'h8, 2'd3);
        // backpressure: word A from requester 1 pending, ptr = 2
        bus.req_data1 = 4'hA;
        step("bp_load", 1'b1, 4'b0010, 1'b1, 4'b0010, 1'b1, 4'hA, 2'd1);
        for (int i = 0; i < 5; i++)
            step("bp_hold", 1'b1, 4'b0110, 1'b0, 4'b0000, 1'b1, 4'hA, 2'd1);
        step("bp_rel", 1'b1, 4'b0110, 1'b1, 4'b0100, 1'b1, 4'h7, 2'd2);
        bus.req_data1 = 4'h6;
        // sparse and skip: ptr 3 -> grant 1 leaves ptr 2; then grant 0, then 3 with wrap
        step("sp_set", 1'b1, 4'b0010, 1'b1, 4'b0010, 1'b1, 4'h6, 2'd1);
        step("sp_skip0", 1'b1, 4'b0001, 1'b1, 4'b0001, 1'b1, 4'h5, 2'd0);
        step("sp_skip3", 1'b1, 4'b1000, 1'b1, 4'b1000, 1'b1, 4'h8, 2'd3);
        step("sp_wrap", 1'b1, 4'hF, 1'b1, 4'b0001, 1'b1, 4'h5, 2'd0);
        // drain to IDLE, idle cycle keeps ptr = 1, then a new request
        step("drain", 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'h5, 2'd0);
        step("idle", 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'h5, 2'd0);
        step("newreq", 1'b1, 4'b0100, 1'b0, 4'b0100, 1'b1, 4'h7, 2'd2);
        // mid-operation reset while holding
        step("hold", 1'b1, 4'hF, 1'b0, 4'b0000, 1'b1, 4'h7, 2'd2);
        step("midrst", 1'b0, 4'hF, 1'b0, 4'b0000, 1'b0, 4'h0, 2'd0);
        step("postrst", 1'b1, 4'hF, 1'b1, 4'b0001, 1'b1, 4'h5, 2'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rr_mux_4_1_arbiter.md
# rr_mux_4_1_arbiter

Round-robin arbiter and sequencer for the 4:1 4-bit multiplexer. Shares one registered 4-bit output channel among four valid/ready requesters. It picks one requester per transfer, drives the existing `mux_4_1` select, captures the selected data into an output register, and holds it until the consumer accepts it. It sits between four producers and a single downstream consumer.

## Interface
- Parameters: none. Data width is fixed at 4 bits to match `mux_4_1`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-low (`rst == 0` resets on the next edge).
- `req_valid`  in  4  bit i set means requester i offers `req_data<i>`.
- `req_data0`..`req_data3`  in  4 each  requester data.
- `req_ready`  out  4  one-hot or zero; bit i set means requester i's data is captured this cycle.
- `out_valid`  out  1  output register holds an unaccepted word.
- `out_data`  out  4  registered selected data.
- `out_sel`  out  2  index of the requester whose data is in `out_data`.
- `out_ready`  in  1  consumer accepts the word when `out_valid && out_ready`.

## Operation
- FSM states: IDLE (output register empty) and HOLD (`out_valid = 1`).
- `capture_en = (state == IDLE) || out_ready`. In HOLD, this means the current word leaves in the same cycle a new one is captured.
- Picker: starting at `ptr`, scan indices `ptr`, `ptr+1`, `ptr+2`, `ptr+3` mod 4. The first index with `req_valid` set is `gnt`. `any` is the OR of `req_valid`.
- `req_ready[gnt] = capture_en && any`, combinational. All other bits are 0. `req_ready` depends combinationally on `out_ready`, `req_valid` and `ptr`.
- On a capture edge:
  - `out_data <= mux_4_1(req_data*, gnt)`
  - `out_sel <= gnt`
  - `ptr <= gnt + 1` (2-bit wrap, so 3+1 = 0)
  - `out_valid <= 1`
  - state goes to HOLD.
- In HOLD:
  - `out_ready = 0`: hold `out_data`, `out_sel`, `out_valid` and `ptr` stable. `req_ready` is all 0.
  - `out_ready = 1` and `any = 1`: back-to-back capture; stay in HOLD.
  - `out_ready = 1` and `any = 0`: `out_valid <= 0`; go to IDLE. `out_data` and `out_sel` keep their last values.
- In IDLE with `any = 0`: nothing changes.
- `ptr` advances only on a capture, never on idle cycles.
- Requesters must hold `req_valid` and data until they see `req_ready`. The arbiter does not check this.

## Timing
- Reset values: state IDLE, `ptr = 0`, `out_valid = 0`, `out_data = 4'h0`, `out_sel = 2'd0`. `req_ready` is all 0 during reset.
- Latency: `req_valid` at cycle N in IDLE gives `req_ready` at N and `out_valid`/`out_data` at N+1.
- Throughput: one word per cycle while `out_ready` is held high and requests are present.
- Fairness: with all four requesting continuously, grants go 0,1,2,3,0,... No requester waits more than 3 transfers.
- Reset during HOLD: the pending word is dropped, `out_valid = 0` on the next edge and `ptr = 0`.
- A `req_valid` that rises in the same cycle as a capture for another index is considered at the next capture opportunity.

## Structure
- Package `rr_mux_pkg`:
  - `N_REQ = 4`, `SEL_W = 2`, `DATA_W = 4`
  - `typedef enum logic {IDLE, HOLD} rr_state_t`
- Sub-module `rr_pick4`: combinational rotate-and-priority picker. Inputs `req_valid[3:0]` and `ptr[1:0]`; outputs `gnt[1:0]` and `any`.
- Data selection instantiates the existing `mux_4_1`, with `sel = gnt` and its `y` feeding the `out_data` register D input.

## Test plan
- Reset: assert `rst = 0` for 2 cycles with `req_valid = 4'hF`. Required: `out_valid = 0`, `req_ready = 0`, `out_sel = 0`. After release: first grant is 0, and `out_data = req_data0` at the next edge.
- Rotation: `req_dataX = X+5`, `req_valid = 4'hF`, `out_ready = 1` for 8 cycles. Required: `out_sel` sequence 0,1,2,3,0,1,2,3 with `out_data` 5,6,7,8,5,6,7,8, and no bubbles.
- Backpressure: with one word pending (`out_data = 4'hA`), hold `out_ready = 0` for 5 cycles while `req_valid = 4'b0110`. Required: `out_data` stays `A`, `req_ready = 0` throughout. When `out_ready` rises, the next capture takes index `ptr`-first.
- Sparse and skip: `ptr = 2`, `req_valid = 4'b0001`. Required: grant 0, `req_ready = 4'b0001`, next `ptr = 1`. Then `req_valid = 4'b1000` gives grant 3 and `ptr` wraps to 0.
- Drain to IDLE: single word accepted with `req_valid = 0`. Required: `out_valid` falls the next cycle and `out_data` is held. A new request then yields `out_valid` one cycle after `req_ready`.
- Mid-operation reset: pull `rst` low while in HOLD with `out_ready = 0`. Required: the next edge gives `out_valid = 0`, `out_data = 0` and `ptr = 0`.
